mcoi_link_reset_sequencer: RTL and testbench
============================================

# mcoi_link_reset_sequencer

Link bring-up and reset sequencer for the MCOI XU5 GBT path, clocked from the 100 MHz free-running oscillator domain. It consumes the status signals produced by the clock/reset system block: optical LOS, external PLL ready, and GBT 40 MHz PLL lock. It also consumes the GBT TX/RX ready flags. From these it drives the staged resets back into the GBT PLL, GBT TX and GBT RX, with per-stage timeouts, automatic retry and a single `link_ready_o` qualifier for the rest of the design.

## Interface
Parameters:
- `g_STABLE_CYCLES`, default 1000: consecutive cycles of ext PLL ready with no LOS required before sequencing starts.
- `g_RST_PULSE`, default 16: cycles each reset pulse is held in its `*_RST` state.
- `g_TIMEOUT`, default 1000000: cycles allowed in a `*_WAIT` state (10 ms at 100 MHz).
- `g_TIMER_W`, default 24: timer width; must hold `max(g_TIMEOUT, g_STABLE_CYCLES)`.

Ports:
- `clk_ik`  in  1  100 MHz clock.
- `rst_ir`  in  1  reset, synchronous, active-high.
- `los_i`  in  1  optical loss of signal; asynchronous.
- `ext_pll_ready_i`  in  1  external PLL ready; asynchronous.
- `gbt_pll_locked_i`  in  1  GBT 40 MHz PLL locked; asynchronous.
- `gbt_tx_ready_i`  in  1  GBT TX ready; asynchronous.
- `gbt_rx_ready_i`  in  1  GBT RX ready; asynchronous.
- `gbt_pll_reset_o`  out  1  GBT PLL reset, active-high.
- `gbt_tx_reset_o`  out  1  GBT TX reset, active-high.
- `gbt_rx_reset_o`  out  1  GBT RX reset, active-high.
- `link_ready_o`  out  1  high only in READY.
- `state_o`  out  3  current state encoding.
- `retry_cnt_o`  out  8  saturating count of timeouts.

## Operation
- **Input synchronization.** Every asynchronous input passes through a 2-FF synchronizer (suffix `_s`). Synchronizer flops reset to 0, except `los` which resets to 1.
- **States.** Encodings:
  - WAIT_EXT = 0
  - PLL_RST = 1
  - PLL_WAIT = 2
  - TX_RST = 3
  - TX_WAIT = 4
  - RX_RST = 5
  - RX_WAIT = 6
  - READY = 7
- **Timer.** A single up-counter `g_TIMER_W` bits wide. It clears to 0 on every state change and otherwise increments by 1, saturating.
- **WAIT_EXT.** The timer also clears whenever `!(ext_pll_ready_s & !los_s)`. Go to PLL_RST when the condition is true and timer == `g_STABLE_CYCLES-1`.
- **`*_RST` states.** Exit to the matching `*_WAIT` state when timer == `g_RST_PULSE-1`. Each such state lasts exactly `g_RST_PULSE` cycles.
- **`*_WAIT` states.**
  - If the stage flag (`gbt_pll_locked_s`, `gbt_tx_ready_s`, `gbt_rx_ready_s`) is 1, advance to the next `*_RST` state, or to READY from RX_WAIT.
  - Otherwise, when timer == `g_TIMEOUT-1`, return to the same stage's `*_RST` and increment `retry_cnt_o`, saturating at 255.
- **READY.** Supervision, highest priority first:
  - ext lost or LOS → WAIT_EXT.
  - `!gbt_pll_locked_s` → PLL_RST.
  - `!gbt_tx_ready_s` → TX_RST.
  - `!gbt_rx_ready_s` → RX_RST.
  - These transitions do not count as retries.
- **Global abort.** In every state other than WAIT_EXT, `!ext_pll_ready_s | los_s` forces WAIT_EXT next cycle. This overrides all other transitions.
- **Reset outputs.** Each is a registered decode of the next state:
  - `gbt_pll_reset_o` = state ∈ {WAIT_EXT, PLL_RST}.
  - `gbt_tx_reset_o` = state ≤ TX_RST.
  - `gbt_rx_reset_o` = state ≤ RX_RST.
  - `link_ready_o` = state == READY.
- **Reset.** `rst_ir` overrides everything, including mid-sequence. Values on reset:
  - state = WAIT_EXT, timer = 0, `retry_cnt_o` = 0.
  - All three resets = 1, `link_ready_o` = 0.
- **Counter lifetime.** `retry_cnt_o` is cleared only by `rst_ir`.

## Timing
- Input-to-decision latency is 2 cycles (synchronizer). The state register updates on the following edge.
- Outputs are registered alongside `state_o` and change in the same cycle as `state_o`. They never glitch.
- `*_RST` dwell: exactly `g_RST_PULSE` cycles.
- `*_WAIT` dwell:
  - Flag high on the synchronized first cycle of the state → 1 cycle in the state.
  - Timeout → exactly `g_TIMEOUT` cycles.
- Simultaneous events:
  - Timeout and flag rising in the same cycle → advance; no retry counted.
  - Abort and any other condition in the same cycle → WAIT_EXT.
- Minimum bring-up time after a clean start is `2 + g_STABLE_CYCLES + 3*g_RST_PULSE + 3` cycles plus synchronizer delay of the flags.
- Timer saturation never wraps; behaviour stays defined for long WAIT_EXT dwell.

## Test plan
Common parameters for all scenarios: `g_STABLE_CYCLES` = 4, `g_RST_PULSE` = 3, `g_TIMEOUT` = 20.
- **Clean bring-up.** All status inputs good, reset released at t0.
  - `state_o` sequence is 0,1,2,3,4,5,6,7.
  - `gbt_pll_reset_o` is high for exactly 3 cycles after WAIT_EXT.
  - `link_ready_o` rises; `retry_cnt_o` = 0.
- **TX timeout.** `gbt_tx_ready_i` is held low.
  - TX_WAIT lasts 20 cycles, then TX_RST again.
  - After 3 timeouts `retry_cnt_o` = 3.
  - Raising `gbt_tx_ready_i` completes the sequence to READY.
- **Abort and glitch filtering.**
  - `los_i` pulse while in READY → WAIT_EXT, all resets = 1, `link_ready_o` = 0.
  - A LOS pulse shorter than the stable window during WAIT_EXT restarts the 4-cycle count.
- **Partial loss in READY.** `gbt_rx_ready_i` drops in READY → RX_RST, with `gbt_pll_reset_o` and `gbt_tx_reset_o` staying 0. `gbt_pll_locked_i` drop → PLL_RST.
- **Saturation.** Force 300 timeouts → `retry_cnt_o` = 255, with no wrap.
- **Reset mid-sequence.** Assert `rst_ir` while in RX_WAIT → next cycle state = 0, `retry_cnt_o` = 0, all resets = 1.

Source files
------------

// File: rtl/mcoi_link_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mcoi_link_reset_sequencer
// Purpose  : Link bring-up and reset sequencer for the MCOI XU5 GBT path.
//            Waits for a stable external PLL with no optical LOS, then walks
//            the GBT PLL, TX and RX through staged reset pulses. Each stage
//            waits for its ready flag with a timeout and automatic retry.
//            In READY the link is supervised, and it falls back to the
//            lowest stage that has been lost.
// Ports    : clk_ik             100 MHz free-running clock
//            rst_ir             synchronous active-high reset
//            los_i              optical loss of signal (async)
//            ext_pll_ready_i    external PLL ready (async)
//            gbt_pll_locked_i   GBT 40 MHz PLL locked (async)
//            gbt_tx_ready_i     GBT TX ready (async)
//            gbt_rx_ready_i     GBT RX ready (async)
//            gbt_pll_reset_o    GBT PLL reset, active-high, registered
//            gbt_tx_reset_o     GBT TX reset, active-high, registered
//            gbt_rx_reset_o     GBT RX reset, active-high, registered
//            link_ready_o       high only in READY
//            state_o            current state encoding
//            retry_cnt_o        saturating count of stage timeouts
// Revision : 1.0 - initial release
// ============================================================================
module mcoi_link_reset_sequencer #(
    parameter int g_STABLE_CYCLES = 1000,
    parameter int g_RST_PULSE     = 16,
    parameter int g_TIMEOUT       = 1000000,
    parameter int g_TIMER_W       = 24
) (
    input  logic       clk_ik,
    input  logic       rst_ir,
    input  logic       los_i,
    input  logic       ext_pll_ready_i,
    input  logic       gbt_pll_locked_i,
    input  logic       gbt_tx_ready_i,
    input  logic       gbt_rx_ready_i,
    output logic       gbt_pll_reset_o,
    output logic       gbt_tx_reset_o,
    output logic       gbt_rx_reset_o,
    output logic       link_ready_o,
    output logic [2:0] state_o,
    output logic [7:0] retry_cnt_o
);

    localparam logic [2:0] c_ST_WAIT_EXT = 3'd0;
    localparam logic [2:0] c_ST_PLL_RST  = 3'd1;
    localparam logic [2:0] c_ST_PLL_WAIT = 3'd2;
    localparam logic [2:0] c_ST_TX_RST   = 3'd3;
    localparam logic [2:0] c_ST_TX_WAIT  = 3'd4;
    localparam logic [2:0] c_ST_RX_RST   = 3'd5;
    localparam logic [2:0] c_ST_RX_WAIT  = 3'd6;
    localparam logic [2:0] c_ST_READY    = 3'd7;

    localparam logic [g_TIMER_W-1:0] c_STABLE_LAST  = g_TIMER_W'(g_STABLE_CYCLES - 1);
    localparam logic [g_TIMER_W-1:0] c_PULSE_LAST   = g_TIMER_W'(g_RST_PULSE - 1);
    localparam logic [g_TIMER_W-1:0] c_TIMEOUT_LAST = g_TIMER_W'(g_TIMEOUT - 1);
    localparam logic [g_TIMER_W-1:0] c_TIMER_MAX    = {g_TIMER_W{1'b1}};

    // Synchronizer bit order: {los, ext_pll_ready, gbt_pll_locked, gbt_tx_ready, gbt_rx_ready}.
    // LOS resets to 1 so the link is treated as lost until proven otherwise.
    localparam logic [4:0] c_SYNC_RST = 5'b10000;

    logic [4:0]           r_sync_meta;
    logic [4:0]           r_sync;
    logic [2:0]           r_state;
    logic [g_TIMER_W-1:0] r_timer;
    logic [7:0]           r_retry_cnt;
    logic                 r_pll_reset;
    logic                 r_tx_reset;
    logic                 r_rx_reset;
    logic                 r_link_ready;

    logic [4:0] w_async;
    logic       w_los_s;
    logic       w_ext_pll_ready_s;
    logic       w_gbt_pll_locked_s;
    logic       w_gbt_tx_ready_s;
    logic       w_gbt_rx_ready_s;
    logic       w_ext_ok;
    logic [2:0] w_next_state;
    logic       w_retry;
    logic       w_timer_clr;

    assign w_async = {los_i, ext_pll_ready_i, gbt_pll_locked_i, gbt_tx_ready_i, gbt_rx_ready_i};

    assign w_los_s            = r_sync[4];
    assign w_ext_pll_ready_s  = r_sync[3];
    assign w_gbt_pll_locked_s = r_sync[2];
    assign w_gbt_tx_ready_s   = r_sync[1];
    assign w_gbt_rx_ready_s   = r_sync[0];

    assign w_ext_ok = w_ext_pll_ready_s & ~w_los_s;

    // Next-state decision. A ready flag in a WAIT state beats a coincident
    // timeout, so the simultaneous case advances without counting a retry.
    always_comb begin
        w_next_state = r_state;
        w_retry      = 1'b0;
        case (r_state)
            c_ST_WAIT_EXT: begin
                if (w_ext_ok && (r_timer == c_STABLE_LAST)) w_next_state = c_ST_PLL_RST;
            end
            c_ST_PLL_RST: begin
                if (r_timer == c_PULSE_LAST) w_next_state = c_ST_PLL_WAIT;
            end
            c_ST_PLL_WAIT: begin
                if (w_gbt_pll_locked_s) begin
                    w_next_state = c_ST_TX_RST;
                end else if (r_timer == c_TIMEOUT_LAST) begin
                    w_next_state = c_ST_PLL_RST;
                    w_retry      = 1'b1;
                end
            end
            c_ST_TX_RST: begin
                if (r_timer == c_PULSE_LAST) w_next_state = c_ST_TX_WAIT;
            end
            c_ST_TX_WAIT: begin
                if (w_gbt_tx_ready_s) begin
                    w_next_state = c_ST_RX_RST;
                end else if (r_timer == c_TIMEOUT_LAST) begin
                    w_next_state = c_ST_TX_RST;
                    w_retry      = 1'b1;
                end
            end
            c_ST_RX_RST: begin
                if (r_timer == c_PULSE_LAST) w_next_state = c_ST_RX_WAIT;
            end
            c_ST_RX_WAIT: begin
                if (w_gbt_rx_ready_s) begin
                    w_next_state = c_ST_READY;
                end else if (r_timer == c_TIMEOUT_LAST) begin
                    w_next_state = c_ST_RX_RST;
                    w_retry      = 1'b1;
                end
            end
            c_ST_READY: begin
                if (!w_ext_ok)                w_next_state = c_ST_WAIT_EXT;
                else if (!w_gbt_pll_locked_s) w_next_state = c_ST_PLL_RST;
                else if (!w_gbt_tx_ready_s)   w_next_state = c_ST_TX_RST;
                else if (!w_gbt_rx_ready_s)   w_next_state = c_ST_RX_RST;
            end
            default: begin
                w_next_state = c_ST_WAIT_EXT;
            end
        endcase

        // Losing the external reference trumps every other decision.
        if ((r_state != c_ST_WAIT_EXT) && !w_ext_ok) begin
            w_next_state = c_ST_WAIT_EXT;
            w_retry      = 1'b0;
        end
    end

    // In WAIT_EXT the timer measures an uninterrupted good window, so any
    // bad cycle restarts it.
    assign w_timer_clr = (w_next_state != r_state) ||
                         ((r_state == c_ST_WAIT_EXT) && !w_ext_ok);

    always_ff @(posedge clk_ik) begin
        if (rst_ir) begin
            r_sync_meta  <= c_SYNC_RST;
            r_sync       <= c_SYNC_RST;
            r_state      <= c_ST_WAIT_EXT;
            r_timer      <= '0;
            r_retry_cnt  <= 8'd0;
            r_pll_reset  <= 1'b1;
            r_tx_reset   <= 1'b1;
            r_rx_reset   <= 1'b1;
            r_link_ready <= 1'b0;
        end else begin
            r_sync_meta <= w_async;
            r_sync      <= r_sync_meta;
            r_state     <= w_next_state;

            if (w_timer_clr) begin
                r_timer <= '0;
            end else if (r_timer != c_TIMER_MAX) begin
                r_timer <= r_timer + 1'b1;
            end

            if (w_retry && (r_retry_cnt != 8'hFF)) begin
                r_retry_cnt <= r_retry_cnt + 8'd1;
            end

            // Outputs decode the next state so they switch with state_o.
            r_pll_reset  <= (w_next_state == c_ST_WAIT_EXT) || (w_next_state == c_ST_PLL_RST);
            r_tx_reset   <= (w_next_state <= c_ST_TX_RST);
            r_rx_reset   <= (w_next_state <= c_ST_RX_RST);
            r_link_ready <= (w_next_state == c_ST_READY);
        end
    end

    assign gbt_pll_reset_o = r_pll_reset;
    assign gbt_tx_reset_o  = r_tx_reset;
    assign gbt_rx_reset_o  = r_rx_reset;
    assign link_ready_o    = r_link_ready;
    assign state_o         = r_state;
    assign retry_cnt_o     = r_retry_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mcoi_link_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcoi_link_reset_sequencer
// Purpose  : Directed self-checking bench for mcoi_link_reset_sequencer with
//            g_STABLE_CYCLES=4, g_RST_PULSE=3, g_TIMEOUT=20.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcoi_link_reset_sequencer;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       los  = 1'b0;
    logic       ext  = 1'b1;
    logic       pll  = 1'b1;
    logic       tx   = 1'b1;
    logic       rx   = 1'b1;
    logic       pll_reset;
    logic       tx_reset;
    logic       rx_reset;
    logic       link_ready;
    logic [2:0] state;
    logic [7:0] retry_cnt;

    int total = 0;
    int bad   = 0;

    mcoi_link_reset_sequencer #(
        .g_STABLE_CYCLES (4),
        .g_RST_PULSE     (3),
        .g_TIMEOUT       (20),
        .g_TIMER_W       (24)
    ) dut (
        .clk_ik           (clk),
        .rst_ir           (rst),
        .los_i            (los),
        .ext_pll_ready_i  (ext),
        .gbt_pll_locked_i (pll),
        .gbt_tx_ready_i   (tx),
        .gbt_rx_ready_i   (rx),
        .gbt_pll_reset_o  (pll_reset),
        .gbt_tx_reset_o   (tx_reset),
        .gbt_rx_reset_o   (rx_reset),
        .link_ready_o     (link_ready),
        .state_o          (state),
        .retry_cnt_o      (retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
        int n;
        n = 0;
        while ((state !== st) && (n < budget)) begin
            tick();
            n++;
        end
        chk(tag, {29'd0, state}, {29'd0, st});
    endtask

    // State after the k-th clock edge following reset release, all inputs good.
    function automatic logic [2:0] bringup_state(input int k);
        if (k <= 5)       return 3'd0;
        else if (k <= 8)  return 3'd1;
        else if (k == 9)  return 3'd2;
        else if (k <= 12) return 3'd3;
        else if (k == 13) return 3'd4;
        else if (k <= 16) return 3'd5;
        else if (k == 17) return 3'd6;
        else              return 3'd7;
    endfunction

    initial begin
        // Reset values
        rst = 1'b1;
        tick_n(3);
        chk("reset_state", state, 0);
        chk("reset_pll_rst", pll_reset, 1);
        chk("reset_tx_rst", tx_reset, 1);
        chk("reset_rx_rst", rx_reset, 1);
        chk("reset_link", link_ready, 0);
        chk("reset_retry", retry_cnt, 0);

        // Clean bring-up: 0,1,2,3,4,5,6,7 with exact dwell times
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("bringup_state", state, bringup_state(k));
            if (k == 6) chk("bringup_pll_rst_on", pll_reset, 1);
            if (k == 8) chk("bringup_pll_rst_last", pll_reset, 1);
            if (k == 9) chk("bringup_pll_rst_off", pll_reset, 0);
        end
        chk("bringup_link", link_ready, 1);
        chk("bringup_pll_rst", pll_reset, 0);
        chk("bringup_tx_rst", tx_reset, 0);
        chk("bringup_rx_rst", rx_reset, 0);
        chk("bringup_retry", retry_cnt, 0);

        // TX timeout: TX_WAIT entered at edge 13, times out after 20 cycles
        rst = 1'b1;
        tx  = 1'b0;
        tick();
        rst = 1'b0;
        tick_n(13);
        chk("txto_enter_wait", state, 4);
        tick_n(19);
        chk("txto_last_wait", state, 4);
        chk("txto_retry0", retry_cnt, 0);
        tick();
        chk("txto_back_rst", state, 3);
        chk("txto_retry1", retry_cnt, 1);
        tick_n(46);
        chk("txto_third_rst", state, 3);
        chk("txto_retry3", retry_cnt, 3);
        tx = 1'b1;
        tick_n(3);
        chk("txto_wait_again", state, 4);
        tick();
        chk("txto_advance", state, 5);
        tick_n(4);
        chk("txto_ready", state, 7);
        chk("txto_link", link_ready, 1);
        chk("txto_retry_kept", retry_cnt, 3);

        // LOS pulse in READY aborts to WAIT_EXT
        los = 1'b1;
        tick();
        los = 1'b0;
        tick();
        chk("abort_sync_delay", state, 7);
        tick();
        chk("abort_state", state, 0);
        chk("abort_pll_rst", pll_reset, 1);
        chk("abort_tx_rst", tx_reset, 1);
        chk("abort_rx_rst", rx_reset, 1);
        chk("abort_link", link_ready, 0);
        chk("abort_no_retry", retry_cnt, 3);

        // Short LOS glitch in WAIT_EXT restarts the stable count
        tick();
        los = 1'b1;
        tick();
        los = 1'b0;
        tick_n(2);
        chk("glitch_hold", state, 0);
        tick_n(3);
        chk("glitch_still_wait", state, 0);
        tick();
        chk("glitch_pll_rst", state, 1);
        wait_state("glitch_reach_ready", 3'd7, 60);

        // Partial loss: RX drop goes to RX_RST only
        rx = 1'b0;
        tick_n(3);
        chk("rxloss_state", state, 5);
        chk("rxloss_pll_rst", pll_reset, 0);
        chk("rxloss_tx_rst", tx_reset, 0);
        chk("rxloss_rx_rst", rx_reset, 1);
        chk("rxloss_link", link_ready, 0);
        rx = 1'b1;
        tick_n(3);
        chk("rxloss_wait", state, 6);
        tick();
        chk("rxloss_ready", state, 7);
        chk("rxloss_no_retry", retry_cnt, 3);

        // Partial loss: PLL unlock goes to PLL_RST
        pll = 1'b0;
        tick_n(3);
        chk("pllloss_state", state, 1);
        chk("pllloss_pll_rst", pll_reset, 1);
        chk("pllloss_tx_rst", tx_reset, 1);
        pll = 1'b1;
        wait_state("pllloss_reach_ready", 3'd7, 60);
        chk("pllloss_no_retry", retry_cnt, 3);

        // Saturation: ~300 TX timeouts, counter must stop at 255
        tx = 1'b0;
        tick_n(300 * 23);
        chk("sat_retry", retry_cnt, 255);

        // Reset while in RX_WAIT
        tx = 1'b1;
        rx = 1'b0;
        wait_state("midrst_reach_rxwait", 3'd6, 200);
        tick_n(2);
        rst = 1'b1;
        tick();
        chk("midrst_state", state, 0);
        chk("midrst_retry", retry_cnt, 0);
        chk("midrst_pll_rst", pll_reset, 1);
        chk("midrst_tx_rst", tx_reset, 1);
        chk("midrst_rx_rst", rx_reset, 1);
        chk("midrst_link", link_ready, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
